// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter in front of a single-port data memory.
//            The core normally wins. A waiting DMA port gains priority after
//            STARVE_MAX lost cycles. While locked it may keep the grant for up
//            to LOCK_MAX consecutive cycles against a requesting core.
//            Out-of-range accesses, meaning address bits [31:10] are nonzero,
//            still win arbitration. Their write strobe is suppressed and they
//            set the sticky addr_err flag.
// Ports    : clk, reset (async, active-low)
//            core_*  : core request/we/addr/wdata in; rdata, stall out
//            dma_*   : DMA request/we/lock/addr/wdata in; ack, rdata, rvalid out
//            mem_*   : word address, write strobe and write data out;
//                      combinational read data in
//            addr_err: sticky out-of-range flag
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        addr_err
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int LOCK_W   = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [STARVE_W-1:0] c_starve_lim = STARVE_W'(STARVE_MAX);
  localparam logic [LOCK_W-1:0]   c_lock_lim   = LOCK_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_DMA  = 2'd2
  } grant_t;

  grant_t               r_state;
  logic [STARVE_W-1:0]  r_starve_cnt;
  logic [LOCK_W-1:0]    r_lock_cnt;
  logic [31:0]          r_dma_rdata;
  logic                 r_dma_rvalid;
  logic                 r_addr_err;

  grant_t               w_win;
  logic [31:0]          w_addr;
  logic [31:0]          w_wdata;
  logic                 w_we;
  logic                 w_oob;
  logic                 w_dma_win;
  logic                 w_unused_lsbs;

  // Winner selection, highest priority first: lock continuation, starvation
  // override, core, then DMA alone.
  always_comb begin
    w_win = ST_IDLE;
    if (r_state == ST_DMA && dma_req && dma_lock && r_lock_cnt < c_lock_lim)
      w_win = ST_DMA;
    else if (dma_req && r_starve_cnt == c_starve_lim)
      w_win = ST_DMA;
    else if (core_req)
      w_win = ST_CORE;
    else if (dma_req)
      w_win = ST_DMA;
  end

  always_comb begin
    w_addr  = 32'd0;
    w_wdata = 32'd0;
    w_we    = 1'b0;
    case (w_win)
      ST_CORE: begin
        w_addr  = core_addr;
        w_wdata = core_wdata;
        w_we    = core_we;
      end
      ST_DMA: begin
        w_addr  = dma_addr;
        w_wdata = dma_wdata;
        w_we    = dma_we;
      end
      default: ;
    endcase
  end

  assign w_dma_win     = (w_win == ST_DMA);
  assign w_oob         = (w_win != ST_IDLE) && (w_addr[31:10] != 22'd0);
  assign w_unused_lsbs = ^w_addr[1:0];

  assign mem_addr   = w_addr[9:2];
  assign mem_wdata  = w_wdata;
  // The strobe is also gated by reset so no write can slip through while
  // the arbiter is held in reset.
  assign mem_we     = w_we && !w_oob && reset;
  assign core_rdata = mem_rdata;
  assign core_stall = core_req && (w_win != ST_CORE);
  assign dma_ack    = w_dma_win;

  assign dma_rdata  = r_dma_rdata;
  assign dma_rvalid = r_dma_rvalid;
  assign addr_err   = r_addr_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_lock_cnt   <= '0;
      r_dma_rdata  <= 32'd0;
      r_dma_rvalid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_state <= w_win;

      // Starvation count: grows only while the DMA waits and loses.
      if (w_dma_win || !dma_req)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != c_starve_lim)
        r_starve_cnt <= r_starve_cnt + 1'b1;

      // Lock count: tracks burst length against a competing core. A DMA win
      // with the core idle leaves it unchanged.
      if (!w_dma_win)
        r_lock_cnt <= '0;
      else if (core_req && r_lock_cnt != c_lock_lim)
        r_lock_cnt <= r_lock_cnt + 1'b1;

      r_dma_rvalid <= w_dma_win && !dma_we;
      if (w_dma_win && !dma_we)
        r_dma_rdata <= mem_rdata;

      if (w_oob)
        r_addr_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Testbench for dmem_arbiter. Directed scenarios with literal
//            expectations are followed by randomized traffic. A behavioural
//            model computes the expected outputs, and a compare process checks
//            them once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 8;
  localparam int G_NONE = 0;
  localparam int G_CORE = 1;
  localparam int G_DMA  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = 32'd0, core_wdata = 32'd0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [31:0] dma_addr = 32'd0, dma_wdata = 32'd0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT.
  logic [31:0] dmem [256];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_prev = G_NONE;
  int          m_starve = 0;
  int          m_lock = 0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  logic [31:0] m_mem [256];

  function automatic int pick_winner();
    if (m_prev == G_DMA && dma_req && dma_lock && m_lock < LOCK_MAX) return G_DMA;
    if (dma_req && m_starve >= STARVE_MAX) return G_DMA;
    if (core_req) return G_CORE;
    if (dma_req) return G_DMA;
    return G_NONE;
  endfunction

  function automatic logic [31:0] win_addr(input int w);
    return (w == G_CORE) ? core_addr : (w == G_DMA) ? dma_addr : 32'd0;
  endfunction

  function automatic logic win_we(input int w);
    return (w == G_CORE) ? core_we : (w == G_DMA) ? dma_we : 1'b0;
  endfunction

  function automatic logic [31:0] win_wdata(input int w);
    return (w == G_CORE) ? core_wdata : (w == G_DMA) ? dma_wdata : 32'd0;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 10) == 32'd0;
  endfunction

  always @(posedge clk or negedge reset) begin
    int          w;
    logic [31:0] a;
    if (!reset) begin
      m_prev   <= G_NONE;
      m_starve <= 0;
      m_lock   <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= 32'd0;
      m_err    <= 1'b0;
    end else begin
      w = pick_winner();
      a = win_addr(w);
      m_prev <= w;
      if (w == G_DMA || !dma_req) m_starve <= 0;
      else m_starve <= (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      if (w != G_DMA) m_lock <= 0;
      else if (core_req) m_lock <= (m_lock + 1 > LOCK_MAX) ? LOCK_MAX : m_lock + 1;
      m_rvalid <= (w == G_DMA) && !dma_we;
      if (w == G_DMA && !dma_we) m_rdata <= m_mem[a[9:2]];
      if (w != G_NONE && !in_range(a)) m_err <= 1'b1;
      if (w != G_NONE && win_we(w) && in_range(a)) m_mem[a[9:2]] <= win_wdata(w);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int          w;
    logic [31:0] a;
    logic        exp_we;
    w = pick_winner();
    a = win_addr(w);
    exp_we = reset && win_we(w) && (w != G_NONE) && in_range(a);
    chk("mem_addr", {24'd0, mem_addr}, {24'd0, a[9:2]});
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (w != G_NONE) chk("mem_wdata", mem_wdata, win_wdata(w));
    chk("core_rdata", core_rdata, m_mem[a[9:2]]);
    chk("core_stall", {31'd0, core_stall}, {31'd0, core_req && (w != G_CORE)});
    chk("dma_ack", {31'd0, dma_ack}, {31'd0, w == G_DMA});
    chk("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rvalid});
    chk("dma_rdata", dma_rdata, m_rdata);
    chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {22'd0, 10'($urandom)};
    if ($urandom_range(0, 31) == 0) a = a | (32'h1 << $urandom_range(10, 31));
    return a;
  endfunction

  initial begin
    repeat (2) next_cycle();
    reset = 1'b1;

    // Core-only write then read.
    next_cycle();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h1234;
    #3;
    chk("A_mem_addr", {24'd0, mem_addr}, 32'd4);
    chk("A_mem_we", {31'd0, mem_we}, 32'd1);
    chk("A_stall_wr", {31'd0, core_stall}, 32'd0);
    next_cycle();
    core_we = 1'b0;
    #3;
    chk("A_core_rdata", core_rdata, 32'h1234);
    chk("A_stall_rd", {31'd0, core_stall}, 32'd0);

    // Contention without lock: DMA wins on the fifth cycle only.
    next_cycle(); idle();
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      core_req = 1'b1; dma_req = 1'b1; core_addr = 32'h10; dma_addr = 32'h40;
      #3;
      chk($sformatf("B_ack_c%0d", i), {31'd0, dma_ack}, {31'd0, i == 5});
      chk($sformatf("B_stall_c%0d", i), {31'd0, core_stall}, {31'd0, i == 5});
    end

    // DMA read with one-cycle return latency.
    next_cycle(); idle();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'hCAFEF00D;
    next_cycle(); idle();
    dma_req = 1'b1; dma_addr = 32'h20;
    #3;
    chk("C_ack", {31'd0, dma_ack}, 32'd1);
    chk("C_mem_addr", {24'd0, mem_addr}, 32'd8);
    next_cycle(); idle();
    #3;
    chk("C_rvalid", {31'd0, dma_rvalid}, 32'd1);
    chk("C_rdata", dma_rdata, 32'hCAFEF00D);
    next_cycle();
    #3;
    chk("C_rvalid_drop", {31'd0, dma_rvalid}, 32'd0);
    chk("C_rdata_hold", dma_rdata, 32'hCAFEF00D);

    // Locked burst: 4 core cycles, 8 DMA grants, then core again.
    next_cycle(); idle();
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      core_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1; core_addr = 32'h14; dma_addr = 32'h48;
      #3;
      chk($sformatf("D_ack_c%0d", i), {31'd0, dma_ack}, {31'd0, i >= 5 && i <= 12});
    end

    // Reset in the third burst cycle aborts the lock.
    next_cycle(); idle();
    for (int i = 1; i <= 7; i++) begin
      next_cycle();
      core_req = 1'b1; core_we = 1'b1; core_addr = 32'h30; core_wdata = i;
      dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 32'h44;
      if (i == 7) begin
        #1 reset = 1'b0;
        #2;
        chk("E_ack_rst", {31'd0, dma_ack}, 32'd0);
        chk("E_we_rst", {31'd0, mem_we}, 32'd0);
        chk("E_rvalid_rst", {31'd0, dma_rvalid}, 32'd0);
      end else begin
        #3;
        chk($sformatf("E_ack_c%0d", i), {31'd0, dma_ack}, {31'd0, i >= 5});
      end
    end
    next_cycle();
    #3;
    chk("E_we_held", {31'd0, mem_we}, 32'd0);
    next_cycle();
    reset = 1'b1;
    #3;
    chk("E_ack_rel", {31'd0, dma_ack}, 32'd0);
    chk("E_stall_rel", {31'd0, core_stall}, 32'd0);
    chk("E_we_rel", {31'd0, mem_we}, 32'd1);

    // Out-of-range core write.
    next_cycle(); idle();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h400; core_wdata = 32'hDEAD;
    #3;
    chk("F_we", {31'd0, mem_we}, 32'd0);
    chk("F_stall", {31'd0, core_stall}, 32'd0);
    chk("F_err_before", {31'd0, addr_err}, 32'd0);
    next_cycle(); idle();
    #3;
    chk("F_err_set", {31'd0, addr_err}, 32'd1);
    repeat (3) next_cycle();
    chk("F_err_sticky", {31'd0, addr_err}, 32'd1);
    next_cycle();
    reset = 1'b0;
    #3;
    chk("F_err_cleared", {31'd0, addr_err}, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Randomized traffic, alternating light and heavy contention phases.
    for (int c = 0; c < 3000; c++) begin
      bit heavy;
      next_cycle();
      heavy = ((c / 200) % 2) == 1;
      reset      = ($urandom_range(0, 99) != 0);
      core_req   = heavy ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 60);
      dma_req    = heavy ? ($urandom_range(0, 99) < 95) : ($urandom_range(0, 99) < 50);
      dma_lock   = heavy ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      core_we    = 1'($urandom_range(0, 1));
      dma_we     = 1'($urandom_range(0, 1));
      core_addr  = rand_addr();
      dma_addr   = rand_addr();
      core_wdata = $urandom;
      dma_wdata  = $urandom;
    end
    next_cycle(); idle(); reset = 1'b1;
    repeat (2) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
